idle_pattern_checker: RTL and testbench

- Sink-side checker for the main-link idle symbol stream. Consumes the 8-bit symbol and control-flag pair produced by the idle pattern generator.
- Hunts for the BS/SR group, then checks every field of each idle pattern: BS group, VB-ID, Mvid, Maud, zero dummies, and the fixed repetition period.
- Reports lock, registered error pulses with a cause code, the captured VB-ID, and a saturating error count.
- Sits in the link-layer test/receive path after symbol alignment.

---
 rtl/idle_pattern_checker.sv | 195 +++++++++++++++++++
 tb/tb_idle_pattern_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/idle_pattern_checker.sv
// Sink-side idle pattern checker: hunts for a BS/SR group, then checks every field
// and the fixed repetition period of each idle pattern, reporting lock and error causes.
module idle_pattern_checker #(
    parameter int PERIOD      = 8192,
    parameter int LOCK_THRESH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idle_rx_en,
    input  logic       rx_valid,
    input  logic [7:0] rx_symbols,
    input  logic       rx_control_sym_flag,
    output logic       idle_locked,
    output logic       idle_err,
    output logic [2:0] idle_err_code,
    output logic       idle_sr_seen,
    output logic [7:0] idle_vb_id,
    output logic [7:0] idle_err_cnt,
    output logic [3:0] dbg_state
);

    localparam int CW = $clog2(PERIOD);

    localparam logic [7:0] SYM_SR    = 8'h0F;
    localparam logic [7:0] SYM_BS    = 8'hBC;
    localparam logic [7:0] SYM_BF    = 8'hBD;
    localparam logic [7:0] SYM_VB_ID = 8'h08;

    localparam logic [2:0] ERR_CTRL  = 3'd1;
    localparam logic [2:0] ERR_HDR   = 3'd2;
    localparam logic [2:0] ERR_DUMMY = 3'd3;
    localparam logic [2:0] ERR_EARLY = 3'd4;
    localparam logic [2:0] ERR_LATE  = 3'd5;

    typedef enum logic [3:0] {
        HUNT    = 4'd0,
        BF1     = 4'd1,
        BF2     = 4'd2,
        BS4     = 4'd3,
        VBID    = 4'd4,
        MVID    = 4'd5,
        MAUD    = 4'd6,
        DUMMY   = 4'd7,
        EXP_BS1 = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] sym_cnt_q, sym_cnt_d;
    logic          sr_mode_q, sr_mode_d;
    logic [3:0]    hdr_ok_q, hdr_ok_d;

    logic       is_sr_k, is_bs_k, is_bf_k, is_start, is_d_zero;
    logic       err_hit, sr_pulse, vb_capture, hdr_clean;
    logic [2:0] err_code_d;

    assign is_sr_k   = rx_control_sym_flag && (rx_symbols == SYM_SR);
    assign is_bs_k   = rx_control_sym_flag && (rx_symbols == SYM_BS);
    assign is_bf_k   = rx_control_sym_flag && (rx_symbols == SYM_BF);
    assign is_start  = is_sr_k || is_bs_k;
    assign is_d_zero = !rx_control_sym_flag && (rx_symbols == 8'h00);
    assign dbg_state = state_q;

    // sym_cnt holds the pattern index of the symbol currently being sampled.
    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q + CW'(1);
        sr_mode_d  = sr_mode_q;
        err_hit    = 1'b0;
        err_code_d = 3'd0;
        sr_pulse   = 1'b0;
        vb_capture = 1'b0;
        hdr_clean  = 1'b0;
        case (state_q)
            HUNT: begin
                if (is_start) begin
                    sr_mode_d = is_sr_k;
                    sym_cnt_d = CW'(1);
                    state_d   = BF1;
                end
            end
            BF1: begin
                if (is_bf_k) state_d = BF2;
                else begin err_hit = 1'b1; err_code_d = ERR_CTRL; end
            end
            BF2: begin
                if (is_bf_k) state_d = BS4;
                else begin err_hit = 1'b1; err_code_d = ERR_CTRL; end
            end
            BS4: begin
                if ((sr_mode_q && is_sr_k) || (!sr_mode_q && is_bs_k)) begin
                    state_d  = VBID;
                    sr_pulse = sr_mode_q;
                end else begin
                    err_hit = 1'b1; err_code_d = ERR_CTRL;
                end
            end
            VBID: begin
                if (!rx_control_sym_flag && (rx_symbols == SYM_VB_ID)) begin
                    vb_capture = 1'b1;
                    state_d    = MVID;
                end else begin
                    err_hit = 1'b1; err_code_d = ERR_HDR;
                end
            end
            MVID: begin
                if (is_d_zero) state_d = MAUD;
                else begin err_hit = 1'b1; err_code_d = ERR_HDR; end
            end
            MAUD: begin
                if (is_d_zero) begin
                    hdr_clean = 1'b1;
                    state_d   = DUMMY;
                end else begin
                    err_hit = 1'b1; err_code_d = ERR_HDR;
                end
            end
            DUMMY: begin
                if (rx_control_sym_flag) begin
                    err_hit = 1'b1; err_code_d = ERR_EARLY;
                end else if (rx_symbols != 8'h00) begin
                    err_hit = 1'b1; err_code_d = ERR_DUMMY;
                end else if (sym_cnt_q == CW'(PERIOD - 1)) begin
                    state_d   = EXP_BS1;
                    sym_cnt_d = '0;
                end
            end
            EXP_BS1: begin
                if (is_start) begin
                    sr_mode_d = is_sr_k;
                    sym_cnt_d = CW'(1);
                    state_d   = BF1;
                end else begin
                    err_hit = 1'b1; err_code_d = ERR_LATE;
                end
            end
            default: state_d = HUNT;
        endcase

        // An offending BS/SR is itself treated as the start of a new pattern.
        if (err_hit) begin
            if (is_start) begin
                sr_mode_d = is_sr_k;
                sym_cnt_d = CW'(1);
                state_d   = BF1;
            end else begin
                state_d = HUNT;
            end
        end

        if (err_hit)                          hdr_ok_d = 4'd0;
        else if (hdr_clean && hdr_ok_q != 4'd15) hdr_ok_d = hdr_ok_q + 4'd1;
        else                                  hdr_ok_d = hdr_ok_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            sym_cnt_q     <= '0;
            sr_mode_q     <= 1'b0;
            hdr_ok_q      <= 4'd0;
            idle_locked   <= 1'b0;
            idle_err      <= 1'b0;
            idle_err_code <= 3'd0;
            idle_sr_seen  <= 1'b0;
            idle_vb_id    <= 8'h00;
            idle_err_cnt  <= 8'h00;
        end else if (!idle_rx_en) begin
            state_q      <= HUNT;
            sym_cnt_q    <= '0;
            hdr_ok_q     <= 4'd0;
            idle_locked  <= 1'b0;
            idle_err     <= 1'b0;
            idle_sr_seen <= 1'b0;
        end else if (!rx_valid) begin
            idle_err     <= 1'b0;
            idle_sr_seen <= 1'b0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            sr_mode_q    <= sr_mode_d;
            hdr_ok_q     <= hdr_ok_d;
            idle_err     <= err_hit;
            idle_sr_seen <= sr_pulse;
            if (err_hit) begin
                idle_err_code <= err_code_d;
                idle_locked   <= 1'b0;
                if (idle_err_cnt != 8'hFF) idle_err_cnt <= idle_err_cnt + 8'd1;
            end else if (hdr_clean && (hdr_ok_d >= 4'(LOCK_THRESH))) begin
                idle_locked <= 1'b1;
            end
            if (vb_capture) idle_vb_id <= rx_symbols;
        end
    end

endmodule

// File: tb/tb_idle_pattern_checker.sv
// Directed bench for idle_pattern_checker with PERIOD=32, LOCK_THRESH=1.
module tb_idle_pattern_checker;

    localparam logic [7:0] SR = 8'h0F;
    localparam logic [7:0] BS = 8'hBC;
    localparam logic [7:0] BF = 8'hBD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       idle_rx_en;
    logic       rx_valid;
    logic [7:0] rx_symbols;
    logic       rx_control_sym_flag;
    logic       idle_locked;
    logic       idle_err;
    logic [2:0] idle_err_code;
    logic       idle_sr_seen;
    logic [7:0] idle_vb_id;
    logic [7:0] idle_err_cnt;
    logic [3:0] dbg_state;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int err_pulses = 0;
    int sr_pulses  = 0;
    int e0;
    int stall_at;

    idle_pattern_checker #(.PERIOD(32), .LOCK_THRESH(1)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .idle_rx_en          (idle_rx_en),
        .rx_valid            (rx_valid),
        .rx_symbols          (rx_symbols),
        .rx_control_sym_flag (rx_control_sym_flag),
        .idle_locked         (idle_locked),
        .idle_err            (idle_err),
        .idle_err_code       (idle_err_code),
        .idle_sr_seen        (idle_sr_seen),
        .idle_vb_id          (idle_vb_id),
        .idle_err_cnt        (idle_err_cnt),
        .dbg_state           (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic k, input logic [7:0] s);
        @(negedge clk);
        rx_valid            = 1'b1;
        rx_control_sym_flag = k;
        rx_symbols          = s;
        @(posedge clk);
        #1;
        if (idle_err)     err_pulses++;
        if (idle_sr_seen) sr_pulses++;
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid            = 1'b0;
            rx_control_sym_flag = 1'($urandom_range(0, 1));
            rx_symbols          = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            chk("stall_err", {31'd0, idle_err}, 32'd0);
            chk("stall_sr", {31'd0, idle_sr_seen}, 32'd0);
        end
    endtask

    task automatic header(input logic sr);
        send(1'b1, sr ? SR : BS);
        send(1'b1, BF);
        send(1'b1, BF);
        send(1'b1, sr ? SR : BS);
        send(1'b0, 8'h08);
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);
    endtask

    task automatic dummies(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; idle_rx_en = 1'b0; rx_valid = 1'b0;
        rx_symbols = 8'h00; rx_control_sym_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", {31'd0, idle_locked}, 32'd0);
        chk("rst_err", {31'd0, idle_err}, 32'd0);
        chk("rst_code", {29'd0, idle_err_code}, 32'd0);
        chk("rst_vb", {24'd0, idle_vb_id}, 32'd0);
        chk("rst_cnt", {24'd0, idle_err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; idle_rx_en = 1'b1;

        // 1: SR-led first pattern, then three BS patterns
        send(1'b1, SR); send(1'b1, BF); send(1'b1, BF);
        chk("t1_sr_early", {31'd0, idle_sr_seen}, 32'd0);
        send(1'b1, SR);
        chk("t1_sr_seen", {31'd0, idle_sr_seen}, 32'd1);
        send(1'b0, 8'h08);
        chk("t1_vb_id", {24'd0, idle_vb_id}, 32'h08);
        send(1'b0, 8'h00);
        chk("t1_unlocked", {31'd0, idle_locked}, 32'd0);
        send(1'b0, 8'h00);
        chk("t1_locked", {31'd0, idle_locked}, 32'd1);
        dummies(25);
        chk("t1_exp_bs1", {28'd0, dbg_state}, 32'd8);
        for (int p = 0; p < 3; p++) begin
            header(1'b0);
            dummies(25);
        end
        chk("t1_sr_pulses", sr_pulses, 32'd1);
        chk("t1_err_pulses", err_pulses, 32'd0);
        chk("t1_err_cnt", {24'd0, idle_err_cnt}, 32'd0);
        chk("t1_still_locked", {31'd0, idle_locked}, 32'd1);

        // 2: early BS at dummy index 20, resync from it
        header(1'b0);
        dummies(13);
        send(1'b1, BS);
        chk("t2_err", {31'd0, idle_err}, 32'd1);
        chk("t2_code", {29'd0, idle_err_code}, 32'd4);
        chk("t2_unlock", {31'd0, idle_locked}, 32'd0);
        chk("t2_cnt", {24'd0, idle_err_cnt}, 32'd1);
        send(1'b1, BF); send(1'b1, BF); send(1'b1, BS);
        send(1'b0, 8'h08); send(1'b0, 8'h00);
        chk("t2_pre_relock", {31'd0, idle_locked}, 32'd0);
        send(1'b0, 8'h00);
        chk("t2_relock", {31'd0, idle_locked}, 32'd1);
        dummies(25);
        send(1'b1, BS);
        chk("t2_next_bs", {31'd0, idle_err}, 32'd0);

        // 3: K(BC) in place of the first BF; BC is taken as a new BS1
        @(negedge clk); rst_n = 1'b0; rx_valid = 1'b0;
        @(posedge clk); #1;
        chk("t3_rst_cnt", {24'd0, idle_err_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        send(1'b1, BS);
        send(1'b1, BS);
        chk("t3_err", {31'd0, idle_err}, 32'd1);
        chk("t3_code", {29'd0, idle_err_code}, 32'd1);
        chk("t3_lock", {31'd0, idle_locked}, 32'd0);
        chk("t3_cnt", {24'd0, idle_err_cnt}, 32'd1);
        chk("t3_state", {28'd0, dbg_state}, 32'd1);
        send(1'b1, BF); send(1'b1, BF); send(1'b1, BS);
        send(1'b0, 8'h08); send(1'b0, 8'h00); send(1'b0, 8'h00);
        chk("t3_relock", {31'd0, idle_locked}, 32'd1);
        dummies(25);

        // 4: bad dummy at index 10, then bad Mvid
        header(1'b0);
        dummies(3);
        send(1'b0, 8'h5A);
        chk("t4_dummy_err", {31'd0, idle_err}, 32'd1);
        chk("t4_dummy_code", {29'd0, idle_err_code}, 32'd3);
        chk("t4_dummy_cnt", {24'd0, idle_err_cnt}, 32'd2);
        chk("t4_dummy_lock", {31'd0, idle_locked}, 32'd0);
        chk("t4_hunt", {28'd0, dbg_state}, 32'd0);
        send(1'b1, BS); send(1'b1, BF); send(1'b1, BF); send(1'b1, BS);
        send(1'b0, 8'h08);
        send(1'b0, 8'h01);
        chk("t4_mvid_err", {31'd0, idle_err}, 32'd1);
        chk("t4_mvid_code", {29'd0, idle_err_code}, 32'd2);
        chk("t4_mvid_cnt", {24'd0, idle_err_cnt}, 32'd3);

        // 5: valid gaps do not disturb the period; one extra dummy is a late BS
        send(1'b1, BS); send(1'b1, BF); send(1'b1, BF);
        stall(5);
        send(1'b1, BS); send(1'b0, 8'h08); send(1'b0, 8'h00); send(1'b0, 8'h00);
        chk("t5_lock", {31'd0, idle_locked}, 32'd1);
        stall_at = int'($urandom_range(7, 31));
        for (int idx = 7; idx < 32; idx++) begin
            if (idx == stall_at) stall(5);
            send(1'b0, 8'h00);
        end
        stall(5);
        e0 = err_pulses;
        send(1'b1, BS);
        chk("t5_bs_on_time", {31'd0, idle_err}, 32'd0);
        send(1'b1, BF); send(1'b1, BF); send(1'b1, BS);
        send(1'b0, 8'h08); send(1'b0, 8'h00); send(1'b0, 8'h00);
        dummies(25);
        chk("t5_no_errs", err_pulses, e0);
        send(1'b0, 8'h00);
        chk("t5_late_err", {31'd0, idle_err}, 32'd1);
        chk("t5_late_code", {29'd0, idle_err_code}, 32'd5);
        chk("t5_late_cnt", {24'd0, idle_err_cnt}, 32'd4);
        chk("t5_late_lock", {31'd0, idle_locked}, 32'd0);

        // 6: reset mid-dummy while locked, then enable drop with count held
        header(1'b0);
        dummies(10);
        chk("t6_locked", {31'd0, idle_locked}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 1'b1; rx_control_sym_flag = 1'b0; rx_symbols = 8'h00;
        @(posedge clk); #1;
        chk("t6_rst_lock", {31'd0, idle_locked}, 32'd0);
        chk("t6_rst_cnt", {24'd0, idle_err_cnt}, 32'd0);
        chk("t6_rst_vb", {24'd0, idle_vb_id}, 32'd0);
        chk("t6_rst_code", {29'd0, idle_err_code}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        e0 = err_pulses;
        dummies(3);
        chk("t6_hunt_quiet", err_pulses, e0);
        header(1'b0);
        chk("t6_relock", {31'd0, idle_locked}, 32'd1);
        dummies(3);
        send(1'b0, 8'h5A);
        chk("t6_err_cnt", {24'd0, idle_err_cnt}, 32'd1);
        chk("t6_err_unlock", {31'd0, idle_locked}, 32'd0);
        header(1'b0);
        chk("t6_relock2", {31'd0, idle_locked}, 32'd1);
        @(negedge clk);
        idle_rx_en = 1'b0; rx_valid = 1'b1; rx_control_sym_flag = 1'b0; rx_symbols = 8'h00;
        @(posedge clk); #1;
        chk("t6_en_lock", {31'd0, idle_locked}, 32'd0);
        chk("t6_en_cnt", {24'd0, idle_err_cnt}, 32'd1);
        chk("t6_en_vb", {24'd0, idle_vb_id}, 32'h08);
        chk("t6_en_code", {29'd0, idle_err_code}, 32'd3);
        chk("t6_en_hunt", {28'd0, dbg_state}, 32'd0);
        @(negedge clk); idle_rx_en = 1'b1; rx_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
